// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, taken-branch flushes,
// data-memory wait freezes with a timeout, and saturating performance counters.
module pipeline_hazard_ctrl #(
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             memread_ID_EX,
    input  logic [4:0]       rd_ID_EX,
    input  logic [4:0]       rs1_IF_ID,
    input  logic [4:0]       rs2_IF_ID,
    input  logic             use_rs1,
    input  logic             use_rs2,
    input  logic             branch_EX_MEM,
    input  logic             z_flag_EX_MEM,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             id_ex_hold,
    output logic             ex_mem_flush,
    output logic             ex_mem_hold,
    output logic             pc_sel_branch,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt,
    output logic [1:0]       fsm_state
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [WC_W-1:0] wait_cnt, wait_cnt_nxt;
    logic            inc_stall, inc_flush, inc_wait, set_timeout;
    logic            ev_taken, ev_wait, ev_lu;

    assign ev_taken  = branch_EX_MEM & z_flag_EX_MEM;
    assign ev_wait   = dmem_req & ~dmem_ready;
    assign ev_lu     = memread_ID_EX & (rd_ID_EX != 5'd0) &
                       ((use_rs1 & (rd_ID_EX == rs1_IF_ID)) | (use_rs2 & (rd_ID_EX == rs2_IF_ID)));
    assign fsm_state = state;

    always_comb begin
        state_nxt     = state;
        wait_cnt_nxt  = wait_cnt;
        inc_stall     = 1'b0;
        inc_flush     = 1'b0;
        inc_wait      = 1'b0;
        set_timeout   = 1'b0;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        id_ex_hold    = 1'b0;
        ex_mem_flush  = 1'b0;
        ex_mem_hold   = 1'b0;
        pc_sel_branch = 1'b0;
        case (state)
            RUN, FLUSH: begin
                state_nxt = RUN;
                // FLUSH ignores TAKEN and LU: the downstream stages only hold bubbles
                if (state == RUN && ev_taken) begin
                    pc_sel_branch = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    ex_mem_flush  = 1'b1;
                    inc_flush     = 1'b1;
                    state_nxt     = FLUSH;
                end else if (ev_wait) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_hold   = 1'b1;
                    ex_mem_hold  = 1'b1;
                    inc_wait     = 1'b1;
                    wait_cnt_nxt = WC_W'(1);
                    state_nxt    = MEM_WAIT;
                end else if (state == RUN && ev_lu) begin
                    pc_write    = 1'b0;
                    if_id_write = 1'b0;
                    id_ex_flush = 1'b1;
                    inc_stall   = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (ev_wait && wait_cnt != WC_MAX) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_hold   = 1'b1;
                    ex_mem_hold  = 1'b1;
                    inc_wait     = 1'b1;
                    wait_cnt_nxt = wait_cnt + WC_W'(1);
                end else begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    if (ev_wait) begin
                        set_timeout = 1'b1;
                    end else if (ev_lu) begin
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                        id_ex_flush = 1'b1;
                        inc_stall   = 1'b1;
                    end
                end
            end
            default: state_nxt = RUN;
        endcase
        if (!reset_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_flush   = 1'b1;
            ex_mem_flush  = 1'b1;
            id_ex_hold    = 1'b0;
            ex_mem_hold   = 1'b0;
            pc_sel_branch = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_cnt_nxt;
            mem_timeout <= mem_timeout | set_timeout;
            if (inc_stall && stall_cnt != CNT_MAX)   stall_cnt   <= stall_cnt + 1'b1;
            if (inc_flush && flush_cnt != CNT_MAX)   flush_cnt   <= flush_cnt + 1'b1;
            if (inc_wait && memwait_cnt != CNT_MAX)  memwait_cnt <= memwait_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second narrow-counter instance checks saturation.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        memread_ID_EX;
    logic [4:0]  rd_ID_EX, rs1_IF_ID, rs2_IF_ID;
    logic        use_rs1, use_rs2, branch_EX_MEM, z_flag_EX_MEM, dmem_req, dmem_ready;
    logic        pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold;
    logic        ex_mem_flush, ex_mem_hold, pc_sel_branch, mem_timeout;
    logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
    logic [1:0]  fsm_state;
    logic [7:0]  s_ctrl;
    logic        s_timeout;
    logic [1:0]  s_stall_cnt, s_flush_cnt, s_memwait_cnt, s_state;

    int vectors    = 0;
    int miscompares = 0;

    // control bundle: pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_flush, ex_mem_hold, pc_sel_branch
    logic [7:0] ctrl;
    assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush, id_ex_hold, ex_mem_flush, ex_mem_hold, pc_sel_branch};

    localparam logic [7:0] C_DEF   = 8'b1100_0000;
    localparam logic [7:0] C_STALL = 8'b0001_0000;
    localparam logic [7:0] C_TAKEN = 8'b1111_0101;
    localparam logic [7:0] C_FRZ   = 8'b0000_1010;
    localparam logic [7:0] C_RST   = 8'b0011_0100;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(16), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .memread_ID_EX(memread_ID_EX), .rd_ID_EX(rd_ID_EX),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .branch_EX_MEM(branch_EX_MEM), .z_flag_EX_MEM(z_flag_EX_MEM), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_write(pc_write), .if_id_write(if_id_write),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .id_ex_hold(id_ex_hold),
        .ex_mem_flush(ex_mem_flush), .ex_mem_hold(ex_mem_hold), .pc_sel_branch(pc_sel_branch),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .memwait_cnt(memwait_cnt), .fsm_state(fsm_state)
    );

    pipeline_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(64)) dut_s (
        .clk(clk), .reset_n(reset_n), .memread_ID_EX(memread_ID_EX), .rd_ID_EX(rd_ID_EX),
        .rs1_IF_ID(rs1_IF_ID), .rs2_IF_ID(rs2_IF_ID), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .branch_EX_MEM(branch_EX_MEM), .z_flag_EX_MEM(z_flag_EX_MEM), .dmem_req(dmem_req),
        .dmem_ready(dmem_ready), .pc_write(s_ctrl[7]), .if_id_write(s_ctrl[6]),
        .if_id_flush(s_ctrl[5]), .id_ex_flush(s_ctrl[4]), .id_ex_hold(s_ctrl[3]),
        .ex_mem_flush(s_ctrl[2]), .ex_mem_hold(s_ctrl[1]), .pc_sel_branch(s_ctrl[0]),
        .mem_timeout(s_timeout), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
        .memwait_cnt(s_memwait_cnt), .fsm_state(s_state)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        memread_ID_EX = 0; rd_ID_EX = 0; rs1_IF_ID = 0; rs2_IF_ID = 0; use_rs1 = 0; use_rs2 = 0;
        branch_EX_MEM = 0; z_flag_EX_MEM = 0; dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] r1, input logic u1,
                          input logic [4:0] r2, input logic u2);
        memread_ID_EX = 1; rd_ID_EX = rd; rs1_IF_ID = r1; use_rs1 = u1; rs2_IF_ID = r2; use_rs2 = u2;
    endtask

    task automatic do_reset();
        reset_n = 0;
        tick();
        tick();
        reset_n = 1;
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        #1;
        vectors++;
        if (ctrl !== C_RST) begin miscompares++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, C_RST); end
        tick();
        tick();
        reset_n = 1;
        #1;
        vectors++;
        if ({stall_cnt, flush_cnt, memwait_cnt} !== 48'd0 || mem_timeout !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state got=%0d/%0d/%0d to=%b exp=0/0/0 to=0", stall_cnt, flush_cnt, memwait_cnt, mem_timeout);
        end
        vectors++;
        if (ctrl !== C_DEF || fsm_state !== 2'd0) begin
            miscompares++; $display("FAIL reset_defaults got=%b st=%0d exp=%b st=0", ctrl, fsm_state, C_DEF);
        end
    endtask

    task automatic test_load_use();
        set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        #1;
        vectors++;
        if (ctrl !== C_STALL) begin miscompares++; $display("FAIL lu_rs1_ctrl got=%b exp=%b", ctrl, C_STALL); end
        tick();
        idle();
        #1;
        vectors++;
        if (stall_cnt !== 16'd1 || ctrl !== C_DEF) begin
            miscompares++; $display("FAIL lu_rs1_cnt got=%0d ctrl=%b exp=1 ctrl=%b", stall_cnt, ctrl, C_DEF);
        end
        // rs1 matches but is unused; rs2 used but differs -> no hazard
        set_lu(5'd7, 5'd7, 1'b0, 5'd3, 1'b1);
        #1;
        vectors++;
        if (ctrl !== C_DEF) begin miscompares++; $display("FAIL lu_unused_ctrl got=%b exp=%b", ctrl, C_DEF); end
        rs2_IF_ID = 5'd7;
        #1;
        vectors++;
        if (ctrl !== C_STALL) begin miscompares++; $display("FAIL lu_rs2_ctrl got=%b exp=%b", ctrl, C_STALL); end
        tick();
        idle();
        #1;
        vectors++;
        if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL lu_rs2_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_x0();
        set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        #1;
        vectors++;
        if (ctrl !== C_DEF) begin miscompares++; $display("FAIL x0_ctrl got=%b exp=%b", ctrl, C_DEF); end
        tick();
        idle();
        #1;
        vectors++;
        if (stall_cnt !== 16'd2) begin miscompares++; $display("FAIL x0_cnt got=%0d exp=2", stall_cnt); end
    endtask

    task automatic test_taken();
        set_lu(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        branch_EX_MEM = 1; z_flag_EX_MEM = 1;
        #1;
        vectors++;
        if (ctrl !== C_TAKEN) begin miscompares++; $display("FAIL taken_ctrl got=%b exp=%b", ctrl, C_TAKEN); end
        tick();
        vectors++;
        if (fsm_state !== 2'd1 || ctrl !== C_DEF) begin
            miscompares++; $display("FAIL flush_cycle got=%b st=%0d exp=%b st=1", ctrl, fsm_state, C_DEF);
        end
        vectors++;
        if (flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
            miscompares++; $display("FAIL taken_cnt got=%0d/%0d exp=1/2", flush_cnt, stall_cnt);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (fsm_state !== 2'd0 || stall_cnt !== 16'd2 || flush_cnt !== 16'd1) begin
            miscompares++; $display("FAIL after_flush got=st%0d %0d/%0d exp=st0 2/1", fsm_state, stall_cnt, flush_cnt);
        end
    endtask

    task automatic test_mem_wait();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (ctrl !== C_FRZ) begin miscompares++; $display("FAIL wait_frz%0d got=%b exp=%b", i, ctrl, C_FRZ); end
            tick();
        end
        dmem_ready = 1;
        #1;
        vectors++;
        if (ctrl !== C_DEF || fsm_state !== 2'd2) begin
            miscompares++; $display("FAIL wait_ready got=%b st=%0d exp=%b st=2", ctrl, fsm_state, C_DEF);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (memwait_cnt !== 16'd3 || fsm_state !== 2'd0 || mem_timeout !== 1'b0) begin
            miscompares++; $display("FAIL wait_cnt got=%0d st=%0d to=%b exp=3 st=0 to=0", memwait_cnt, fsm_state, mem_timeout);
        end
    endtask

    task automatic test_flush_then_wait();
        branch_EX_MEM = 1; z_flag_EX_MEM = 1;
        tick();
        branch_EX_MEM = 0; z_flag_EX_MEM = 0; dmem_req = 1; dmem_ready = 0;
        #1;
        vectors++;
        if (ctrl !== C_FRZ || fsm_state !== 2'd1) begin
            miscompares++; $display("FAIL flush_wait got=%b st=%0d exp=%b st=1", ctrl, fsm_state, C_FRZ);
        end
        tick();
        dmem_ready = 1;
        #1;
        vectors++;
        if (fsm_state !== 2'd2 || ctrl !== C_DEF) begin
            miscompares++; $display("FAIL flush_wait_rel got=%b st=%0d exp=%b st=2", ctrl, fsm_state, C_DEF);
        end
        tick();
        idle();
        #1;
        vectors++;
        if (flush_cnt !== 16'd2 || memwait_cnt !== 16'd4) begin
            miscompares++; $display("FAIL flush_wait_cnt got=%0d/%0d exp=2/4", flush_cnt, memwait_cnt);
        end
    endtask

    task automatic test_timeout();
        dmem_req = 1; dmem_ready = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (ctrl !== C_FRZ) begin miscompares++; $display("FAIL to_frz%0d got=%b exp=%b", i, ctrl, C_FRZ); end
            tick();
        end
        #1;
        vectors++;
        if (ctrl !== C_DEF) begin miscompares++; $display("FAIL to_release got=%b exp=%b", ctrl, C_DEF); end
        tick();
        dmem_req = 0;
        #1;
        vectors++;
        if (mem_timeout !== 1'b1 || memwait_cnt !== 16'd8 || fsm_state !== 2'd0) begin
            miscompares++; $display("FAIL to_flag got=%b %0d st=%0d exp=1 8 st=0", mem_timeout, memwait_cnt, fsm_state);
        end
        tick();
        vectors++;
        if (mem_timeout !== 1'b1) begin miscompares++; $display("FAIL to_sticky got=%b exp=1", mem_timeout); end
        // reset while frozen aborts the wait and clears the flag
        dmem_req = 1;
        tick();
        tick();
        reset_n = 0;
        #1;
        vectors++;
        if (ctrl !== C_RST) begin miscompares++; $display("FAIL rst_mid_ctrl got=%b exp=%b", ctrl, C_RST); end
        tick();
        reset_n = 1; dmem_req = 0;
        #1;
        vectors++;
        if (fsm_state !== 2'd0 || mem_timeout !== 1'b0 || memwait_cnt !== 16'd0 || ctrl !== C_DEF) begin
            miscompares++; $display("FAIL rst_mid got=st%0d to=%b mw=%0d ctrl=%b exp=st0 to=0 mw=0 ctrl=%b",
                                    fsm_state, mem_timeout, memwait_cnt, ctrl, C_DEF);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        set_lu(5'd12, 5'd0, 1'b0, 5'd12, 1'b1);
        for (int i = 0; i < 5; i++) tick();
        idle();
        #1;
        vectors++;
        if (stall_cnt !== 16'd5) begin miscompares++; $display("FAIL sat_wide got=%0d exp=5", stall_cnt); end
        vectors++;
        if (s_stall_cnt !== 2'd3) begin miscompares++; $display("FAIL sat_narrow got=%0d exp=3", s_stall_cnt); end
    endtask

    initial begin
        reset_n = 0;
        idle();
        test_reset();
        test_load_use();
        test_x0();
        test_taken();
        test_mem_wait();
        test_flush_then_wait();
        test_timeout();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
